// File: rtl/binary_game_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// binary_game_ctrl_pkg
// Shared definitions for the "count binary" DIP-switch game sequencer:
// FSM state codes (also visible on state_o), the LFSR tap mask, the shared
// timer width and the LFSR step function.
// ---------------------------------------------------------------------------
package binary_game_ctrl_pkg;

  localparam int TIMER_W = 24;

  // State codes are exported on state_o, so the values are fixed.
  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_LOAD   = 3'd1;
  localparam logic [2:0] ST_SHOW   = 3'd2;
  localparam logic [2:0] ST_WAIT   = 3'd3;
  localparam logic [2:0] ST_JUDGE  = 3'd4;
  localparam logic [2:0] ST_RESULT = 3'd5;
  localparam logic [2:0] ST_FINAL  = 3'd6;

  // Taps 8,6,5,4 of x^8+x^6+x^5+x^4+1 (maximal length, never hits zero).
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

  typedef logic [3:0] nibble_t;

  function automatic logic [7:0] lfsr_next(input logic [7:0] s);
    return {s[6:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/binary_game_ctrl_btn_debounce.sv
// ---------------------------------------------------------------------------
// btn_debounce
// Two-flop synchroniser, stability counter and rising-edge pulse for the raw
// submit button. A new level is accepted only after DEBOUNCE_CYC consecutive
// equal synchronised samples; o_pulse is high for one cycle when the accepted
// level goes 0->1 (release produces no pulse). Latency: 2 + DEBOUNCE_CYC.
// Ports:
//   clk      in   system clock
//   rst_n    in   synchronous active-low reset
//   i_btn    in   raw asynchronous button
//   o_pulse  out  one-cycle pulse on debounced press
// ---------------------------------------------------------------------------
module btn_debounce #(
  parameter int DEBOUNCE_CYC = 50000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_btn,
  output logic o_pulse
);

  localparam int                CNT_W    = $clog2(DEBOUNCE_CYC + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);

  logic             r_sync1;
  logic             r_sync2;
  logic             r_stable;
  logic             r_pulse;
  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sync1  <= 1'b0;
      r_sync2  <= 1'b0;
      r_stable <= 1'b0;
      r_pulse  <= 1'b0;
      r_cnt    <= '0;
    end else begin
      r_sync1 <= i_btn;
      r_sync2 <= r_sync1;
      r_pulse <= 1'b0;
      // Any sample agreeing with the accepted level restarts the count.
      if (r_sync2 == r_stable) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_LAST) begin
        r_cnt    <= '0;
        r_stable <= r_sync2;
        r_pulse  <= r_sync2;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign o_pulse = r_pulse;

endmodule

// File: rtl/binary_game_ctrl.sv
// ---------------------------------------------------------------------------
// binary_game_ctrl
// Round sequencer for the "count binary" game: shows a pseudo-random 4-bit
// target, hides it, takes the player's DIP-switch answer on a debounced
// button press, shows pass/fail, and after ROUNDS rounds shows the score.
// Optional feature macro: GAME_TIMEOUT_EN (input window times out after
// TIMEOUT_CYC cycles and the round is scored as wrong).
// Ports:
//   clk      in   system clock
//   rst_n    in   synchronous active-low reset
//   sw[3:0]  in   player DIP switches (asynchronous)
//   btn      in   raw submit/start button (asynchronous, bouncy)
//   digit    out  nibble for the 7-seg decoder
//   dp       out  decimal point: answer correct / final-score marker
//   blank    out  1 = decoder output forced off by the top level
//   state_o  out  current FSM state (debug)
//   score    out  correct answers in the current game
// ---------------------------------------------------------------------------
module binary_game_ctrl
  import binary_game_ctrl_pkg::*;
#(
  parameter int         ROUNDS       = 5,
  parameter int         DEBOUNCE_CYC = 50000,
  parameter int         SHOW_CYC     = 1000000,
  parameter int         RESULT_CYC   = 500000,
`ifdef GAME_TIMEOUT_EN
  parameter int         TIMEOUT_CYC  = 5000000,
`endif
  parameter logic [7:0] LFSR_SEED    = 8'hA5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] sw,
  input  logic       btn,
  output logic [3:0] digit,
  output logic       dp,
  output logic       blank,
  output logic [2:0] state_o,
  output logic [3:0] score
);

  localparam logic [TIMER_W-1:0] SHOW_LAST   = TIMER_W'(SHOW_CYC - 1);
  localparam logic [TIMER_W-1:0] RESULT_LAST = TIMER_W'(RESULT_CYC - 1);
  localparam logic [3:0]         ROUNDS_N    = 4'(ROUNDS);

  logic [2:0]         r_state;
  logic [2:0]         w_state_nxt;
  logic [7:0]         r_lfsr;
  nibble_t            r_tgt;
  logic               r_ok;
  logic               r_miss;
  logic [3:0]         r_score;
  logic [3:0]         r_round;
  logic [TIMER_W-1:0] r_timer;
  logic [3:0]         r_sw_s1;
  logic [3:0]         r_sw_s2;
  logic               w_btn_pulse;
  logic               w_show_done;
  logic               w_result_done;
  logic               w_timeout;
  logic               w_ok;
  logic               w_timed;

  btn_debounce #(
    .DEBOUNCE_CYC(DEBOUNCE_CYC)
  ) u_btn (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_btn  (btn),
    .o_pulse(w_btn_pulse)
  );

  // Switch synchroniser: pure data path, no reset needed.
  always_ff @(posedge clk) begin
    r_sw_s1 <= sw;
    r_sw_s2 <= r_sw_s1;
  end

  assign w_show_done   = (r_timer == SHOW_LAST);
  assign w_result_done = (r_timer == RESULT_LAST);
  assign w_timed       = (r_state == ST_SHOW) || (r_state == ST_WAIT) ||
                         (r_state == ST_RESULT);

`ifdef GAME_TIMEOUT_EN
  localparam logic [TIMER_W-1:0] TIMEOUT_LAST = TIMER_W'(TIMEOUT_CYC - 1);
  assign w_timeout = (r_timer == TIMEOUT_LAST);
`else
  assign w_timeout = 1'b0;
`endif

  // A timed-out round is wrong regardless of the switches.
  assign w_ok = !r_miss && (r_sw_s2 == r_tgt);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:   if (w_btn_pulse) w_state_nxt = ST_LOAD;
      ST_LOAD:   w_state_nxt = ST_SHOW;
      // Presses during SHOW/RESULT are simply not looked at.
      ST_SHOW:   if (w_show_done) w_state_nxt = ST_WAIT;
      ST_WAIT:   if (w_btn_pulse || w_timeout) w_state_nxt = ST_JUDGE;
      ST_JUDGE:  w_state_nxt = ST_RESULT;
      ST_RESULT: if (w_result_done)
                   w_state_nxt = (r_round == ROUNDS_N) ? ST_FINAL : ST_LOAD;
      ST_FINAL:  if (w_btn_pulse) w_state_nxt = ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_lfsr  <= LFSR_SEED;
      r_tgt   <= '0;
      r_ok    <= 1'b0;
      r_miss  <= 1'b0;
      r_score <= '0;
      r_round <= '0;
      r_timer <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_lfsr  <= lfsr_next(r_lfsr);

      // One timer serves every timed state; restart it on each state change.
      if (w_state_nxt != r_state)
        r_timer <= '0;
      else if (w_timed)
        r_timer <= r_timer + 1'b1;

      case (r_state)
        ST_IDLE: if (w_btn_pulse) begin
          r_score <= '0;
          r_round <= '0;
        end
        // Bump a repeated target so consecutive rounds always differ.
        ST_LOAD: r_tgt <= (r_lfsr[3:0] == r_tgt) ? r_lfsr[3:0] + 4'd1 : r_lfsr[3:0];
        // A press in the same cycle as the timeout is a normal submit.
        ST_WAIT: r_miss <= w_timeout && !w_btn_pulse;
        ST_JUDGE: begin
          r_ok    <= w_ok;
          r_round <= r_round + 4'd1;
          if (w_ok && (r_score != 4'hF))
            r_score <= r_score + 4'd1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    digit = '0;
    dp    = 1'b0;
    blank = 1'b1;
    case (r_state)
      ST_SHOW: begin
        digit = r_tgt;
        blank = 1'b0;
      end
      ST_RESULT: begin
        digit = r_tgt;
        dp    = r_ok;
        blank = 1'b0;
      end
      ST_FINAL: begin
        digit = r_score;
        dp    = 1'b1;
        blank = 1'b0;
      end
      default: ;
    endcase
  end

  assign state_o = r_state;
  assign score   = r_score;

endmodule

// File: tb/tb_binary_game_ctrl.sv
module tb_binary_game_ctrl;

  localparam int         ROUNDS       = 3;
  localparam int         DEBOUNCE_CYC = 4;
  localparam int         SHOW_CYC     = 8;
  localparam int         RESULT_CYC   = 6;
  localparam int         TIMEOUT_CYC  = 20;
  localparam logic [7:0] SEED         = 8'hA5;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       btn   = 1'b0;
  logic [3:0] sw    = 4'd0;
  logic [3:0] digit;
  logic       dp;
  logic       blank;
  logic [2:0] state_o;
  logic [3:0] score;

  int          checks    = 0;
  int          failures  = 0;
  int          exp_score = 0;
  int unsigned cyc       = 0;
  logic [3:0]  prev_tgt  = 4'd0;
  logic [3:0]  last_shown;
  bit          have_last = 1'b0;

  binary_game_ctrl #(
    .ROUNDS      (ROUNDS),
    .DEBOUNCE_CYC(DEBOUNCE_CYC),
    .SHOW_CYC    (SHOW_CYC),
    .RESULT_CYC  (RESULT_CYC),
`ifdef GAME_TIMEOUT_EN
    .TIMEOUT_CYC (TIMEOUT_CYC),
`endif
    .LFSR_SEED   (SEED)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .sw     (sw),
    .btn    (btn),
    .digit  (digit),
    .dp     (dp),
    .blank  (blank),
    .state_o(state_o),
    .score  (score)
  );

  always #5 clk = ~clk;

  // Clock edges seen since the LFSR was last loaded with the seed.
  always @(posedge clk) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference LFSR: x^8+x^6+x^5+x^4+1, n shifts from the seed.
  function automatic logic [7:0] lfsr_at(input int unsigned n);
    logic [7:0] x;
    x = SEED;
    for (int unsigned i = 0; i < n; i++)
      x = {x[6:0], x[7] ^ x[5] ^ x[4] ^ x[3]};
    return x;
  endfunction

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_state"}, state_o, 0);
    chk({tag, "_digit"}, digit, 0);
    chk({tag, "_dp"},    dp, 0);
    chk({tag, "_blank"}, blank, 1);
    chk({tag, "_score"}, score, 0);
  endtask

  // Enters at IDLE; leaves at the LOAD cycle with the press released.
  task automatic start_game();
    btn = 1'b1;
    step(DEBOUNCE_CYC + 2);
    chk("start_latency_idle", state_o, 0);
    step(1);
    btn = 1'b0;
    exp_score = 0;
  endtask

  // Enters at the LOAD cycle; leaves at the next LOAD/FINAL cycle,
  // or just after reset when abort_here is set.
  task automatic play_round(input logic [3:0] sw_xor, input int pre,
                            input bit show_press, input bit no_press,
                            input bit abort_here);
    logic [7:0] l;
    logic [3:0] exp_tgt;
    bit         exp_ok;
    int         n;
    chk("load_state", state_o, 1);
    chk("load_score", score, exp_score);
    l = lfsr_at(cyc);
    exp_tgt = l[3:0];
    if (exp_tgt == prev_tgt) exp_tgt = exp_tgt + 4'd1;
    prev_tgt = exp_tgt;
    step(1);
    chk("show_digit", digit, exp_tgt);
    chk("show_blank", blank, 0);
    chk("show_dp", dp, 0);
    if (have_last) chk("tgt_repeat", int'(digit != last_shown), 1);
    last_shown = digit;
    have_last  = 1'b1;
    sw = exp_tgt ^ sw_xor;
    if (show_press) btn = 1'b1;
    n = 0;
    while (state_o == 3'd2 && n < 40) begin
      n++;
      if (n == DEBOUNCE_CYC + 2) btn = 1'b0;
      step(1);
    end
    btn = 1'b0;
    chk("show_len", n, SHOW_CYC);
    chk("wait_state", state_o, 3);
    chk("wait_blank", blank, 1);
    if (no_press) begin
      n = 0;
      while (state_o == 3'd3 && n < 60) begin
        n++;
        step(1);
      end
      chk("wait_timeout_len", n, TIMEOUT_CYC);
      exp_ok = 1'b0;
    end else begin
      step(pre + (show_press ? 4 : 0));
      btn = 1'b1;
      step(DEBOUNCE_CYC + 3);
      chk("judge_state", state_o, 4);
      btn = 1'b0;
      exp_ok = (sw_xor == 4'd0);
    end
    step(1);
    if (exp_ok) exp_score++;
    chk("result_state", state_o, 5);
    chk("result_digit", digit, exp_tgt);
    chk("result_dp", dp, int'(exp_ok));
    chk("result_blank", blank, 0);
    chk("result_score", score, exp_score);
    if (abort_here) begin
      step(2);
      rst_n = 1'b0;
      step(1);
      chk_reset("midgame_rst");
      step(1);
      rst_n = 1'b1;
      step(1);
      chk_reset("midgame_rel");
      prev_tgt  = 4'd0;
      have_last = 1'b0;
      return;
    end
    n = 0;
    while (state_o == 3'd5 && n < 40) begin
      n++;
      step(1);
    end
    chk("result_len", n, RESULT_CYC);
  endtask

  task automatic play_game(input logic [3:0] x0, input logic [3:0] x1,
                           input logic [3:0] x2, input int abort_r,
                           input int tmo_r, input int press_r);
    logic [3:0] xr [3];
    xr[0] = x0;
    xr[1] = x1;
    xr[2] = x2;
    step(10);
    start_game();
    for (int r = 0; r < ROUNDS; r++) begin
      play_round(xr[r], int'($urandom_range(0, 6)), r == press_r,
                 r == tmo_r, r == abort_r);
      if (r == abort_r) return;
    end
    chk("final_state", state_o, 6);
    chk("final_digit", digit, exp_score);
    chk("final_dp", dp, 1);
    chk("final_blank", blank, 0);
    btn = 1'b1;
    step(DEBOUNCE_CYC + 2);
    chk("final_hold", state_o, 6);
    step(1);
    btn = 1'b0;
    chk("back_to_idle", state_o, 0);
    chk("idle_blank", blank, 1);
  endtask

  function automatic logic [3:0] rand_xor();
    return ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
  endfunction

  initial begin
    // Reset held three cycles, then released.
    step(3);
    chk_reset("in_reset");
    rst_n = 1'b1;
    step(1);
    chk_reset("after_reset");

    // Short glitch must not start a game.
    btn = 1'b1;
    step(2);
    btn = 1'b0;
    step(10);
    chk("glitch_idle", state_o, 0);

    // All answers right, with a press ignored during SHOW of round 2.
    play_game(4'd0, 4'd0, 4'd0, -1, -1, 1);
    chk("game1_score", exp_score, ROUNDS);

    // Wrong answer in round 2.
    play_game(4'd0, 4'd1, 4'd0, -1, -1, -1);
    chk("game2_score", exp_score, 2);

    // Reset during RESULT of round 2, then a fresh random game.
    play_game(4'd0, 4'd0, 4'd0, 1, -1, -1);
    play_game(rand_xor(), rand_xor(), rand_xor(), -1, -1, 2);

`ifdef GAME_TIMEOUT_EN
    // No press in round 2: window expires and the round scores wrong.
    play_game(4'd0, 4'd0, 4'd0, -1, 1, -1);
    chk("timeout_score", exp_score, 2);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
